eth_build: RTL and testbench

ETH_BUILD -- requirements
Module: eth_build

---
 rtl/eth_pkg.sv | 32 +++
 rtl/eth_build_if.sv | 35 +++
 rtl/ip_csum.sv | 36 +++
 rtl/eth_build.sv | 219 +++++++++++++++++++++
 tb/tb_eth_build.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// eth_pkg: shared definitions for the Ethernet/IPv4/UDP frame builder and the
// matching receive parser.
//   state_t       - builder FSM encoding
//   constants     - fixed header field values and size limits
//   nibble_swap() - TX byte lane nibble order used on the RAM interface
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CSUM    = 3'd1,
    ST_HDR     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  PROTO_UDP      = 8'h11;
  localparam logic [7:0]  PREAMBLE       = 8'h55;
  localparam logic [7:0]  SFD            = 8'hD5;
  localparam int          HDR_BYTES      = 50;
  localparam logic [10:0] MAX_PAYLOAD    = 11'd1232;

  // Header words 0..11 are pure header; word 12 mixes header and payload.
  localparam logic [8:0]  LAST_HDR_WORD  = 9'd11;
  localparam logic [8:0]  FIRST_PL_WORD  = 9'd12;
  localparam logic [8:0]  LAST_CSUM_HW   = 9'd9;

  function automatic logic [7:0] nibble_swap(input logic [7:0] b);
    return {b[3:0], b[7:4]};
  endfunction

endpackage

// File: rtl/eth_build_if.sv
// eth_build_if: request, payload-RAM read, TX-RAM write and status signals of
// the frame builder.
//   slave  - builder side (eth_build)
//   master - requester / RAM side
// Handshake: start is a single-cycle request sampled only while the builder
// is idle (busy=0); there is no ready, a request outside idle is dropped.
// rd_data must return the word addressed by rd_addr one clock later.
// wr_ena qualifies wr_addr/wr_data on every clock it is high.
interface eth_build_if;
  import eth_pkg::*;

  logic        start;
  logic [10:0] payload_len;
  logic [8:0]  rd_addr;
  logic [31:0] rd_data;
  logic [8:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ena;
  logic        busy;
  logic        done;
  logic        err;
  logic [8:0]  last_addr;
  state_t      state;

  modport slave (
    input  start, payload_len, rd_data,
    output rd_addr, wr_addr, wr_data, wr_ena, busy, done, err, last_addr, state
  );

  modport master (
    output start, payload_len, rd_data,
    input  rd_addr, wr_addr, wr_data, wr_ena, busy, done, err, last_addr, state
  );

endinterface

// File: rtl/ip_csum.sv
// ip_csum: IPv4 header checksum accumulator.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - zero the accumulator
//   add        - accumulate din (ignored when clr is high)
//   din        - 16-bit header halfword
//   csum       - folded, inverted checksum of everything accumulated
module ip_csum (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        add,
  input  logic [15:0] din,
  output logic [15:0] csum
);

  logic [19:0] acc_q, acc_d;
  logic [16:0] fold1;
  logic [15:0] fold2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  always_comb begin
    acc_d = acc_q;
    if (clr)      acc_d = '0;
    else if (add) acc_d = acc_q + {4'b0, din};
  end

  // Two end-around folds: the first can itself carry out once more.
  assign fold1 = {1'b0, acc_q[15:0]} + {13'b0, acc_q[19:16]};
  assign fold2 = fold1[15:0] + {15'b0, fold1[16]};
  assign csum  = ~fold2;

endmodule

// File: rtl/eth_build.sv
// eth_build: assembles preamble + Ethernet + IPv4 + UDP header + payload into
// a word-wide TX RAM, nibble-swapped per byte.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - eth_build_if.slave: start/payload_len request, payload RAM
//                read port (1-cycle latency), TX RAM write port, busy/done/err
//                status, last_addr and debug state
// Flow: IDLE -> CSUM (10 halfwords) -> HDR (words 0..11) -> PAYLOAD
// (words 12..12+n) -> DONE. The 50-byte header leaves payload two lanes off
// word alignment, so the upper half of each payload word is carried into the
// next TX word.
module eth_build
  import eth_pkg::*;
#(
  parameter logic [47:0] SRC_MAC  = 48'h02_00_00_00_00_01,
  parameter logic [47:0] DST_MAC  = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [31:0] SRC_IP   = 32'hC0A8_0102,
  parameter logic [31:0] DST_IP   = 32'hC0A8_0101,
  parameter logic [15:0] SRC_PORT = 16'd4096,
  parameter logic [15:0] DST_PORT = 16'd4096,
  parameter logic [7:0]  TTL      = 8'd64
) (
  input logic       clk,
  input logic       rst_n,
  eth_build_if.slave bus
);

  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [10:0] len_q, len_d;
  logic [15:0] id_q, id_d;
  logic [15:0] carry_q, carry_d;
  logic [8:0]  rd_addr_q, rd_addr_d;
  logic [8:0]  last_addr_q, last_addr_d;
  logic        err_q, err_d;

  logic [10:0]  start_len;
  logic         len_ok;
  logic [8:0]   n_words;
  logic [8:0]   last_word;
  logic [15:0]  tot_len, udp_len, csum;
  logic         csum_clr, csum_add;
  logic [15:0]  csum_din;
  logic [399:0] hdr_vec;
  logic [31:0]  hdr_word;
  logic [3:0][7:0] wr_lane;

  assign start_len = bus.payload_len & 11'h7FC;
  assign len_ok    = (start_len != 11'd0) && (start_len <= MAX_PAYLOAD);
  assign n_words   = {1'b0, len_q[10:3], len_q[2]};
  assign last_word = FIRST_PL_WORD + n_words;
  assign tot_len   = 16'd28 + {5'b0, len_q};
  assign udp_len   = 16'd8 + {5'b0, len_q};

  // Frame bytes 0..49, byte 0 in the top bits.
  assign hdr_vec = {{7{PREAMBLE}}, SFD, DST_MAC, SRC_MAC, ETHERTYPE_IPV4,
                    8'h45, 8'h00, tot_len, id_q, 16'h4000, TTL, PROTO_UDP,
                    csum, SRC_IP, DST_IP, SRC_PORT, DST_PORT, udp_len, 16'h0000};
  // Only meaningful for cnt_q 0..11 (HDR).
  assign hdr_word = hdr_vec[10'd399 - {1'b0, cnt_q[3:0], 5'b0} -: 32];

  ip_csum u_csum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (csum_clr),
    .add   (csum_add),
    .din   (csum_din),
    .csum  (csum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      id_q        <= '0;
      carry_q     <= '0;
      rd_addr_q   <= '0;
      last_addr_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      id_q        <= id_d;
      carry_q     <= carry_d;
      rd_addr_q   <= rd_addr_d;
      last_addr_q <= last_addr_d;
      err_q       <= err_d;
    end
  end

  // Next state and shared word/halfword counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.start && len_ok) state_d = ST_CSUM;
      end
      ST_CSUM: begin
        if (cnt_q == LAST_CSUM_HW) begin
          state_d = ST_HDR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      ST_HDR: begin
        cnt_d = cnt_q + 9'd1;
        if (cnt_q == LAST_HDR_WORD) state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (cnt_q == last_word) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers, checksum control and payload read address.
  always_comb begin
    len_d       = len_q;
    id_d        = id_q;
    carry_d     = carry_q;
    rd_addr_d   = rd_addr_q;
    last_addr_d = last_addr_q;
    err_d       = 1'b0;
    csum_clr    = 1'b0;
    csum_add    = 1'b0;

    unique case (cnt_q[3:0])
      4'd0:    csum_din = 16'h4500;
      4'd1:    csum_din = tot_len;
      4'd2:    csum_din = id_q;
      4'd3:    csum_din = 16'h4000;
      4'd4:    csum_din = {TTL, PROTO_UDP};
      4'd6:    csum_din = SRC_IP[31:16];
      4'd7:    csum_din = SRC_IP[15:0];
      4'd8:    csum_din = DST_IP[31:16];
      4'd9:    csum_din = DST_IP[15:0];
      default: csum_din = 16'h0000;   // checksum field itself counts as zero
    endcase

    unique case (state_q)
      ST_IDLE: begin
        rd_addr_d = '0;
        if (bus.start) begin
          len_d = start_len;
          if (len_ok) csum_clr = 1'b1;
          else        err_d    = 1'b1;
        end
      end
      ST_CSUM: csum_add = 1'b1;
      ST_HDR: begin
        // Header bytes 48,49 become lanes 0,1 of word 12.
        carry_d = {hdr_vec[7:0], hdr_vec[15:8]};
        // rd_addr 0 is presented during word 11 so word 0 is back for word 12;
        // advance from there, saturating at the last payload word.
        if (cnt_q == LAST_HDR_WORD && rd_addr_q < n_words - 9'd1)
          rd_addr_d = rd_addr_q + 9'd1;
      end
      ST_PAYLOAD: begin
        carry_d = bus.rd_data[31:16];
        if (rd_addr_q < n_words - 9'd1) rd_addr_d = rd_addr_q + 9'd1;
        if (cnt_q == last_word) last_addr_d = cnt_q;
      end
      ST_DONE: begin
        id_d      = id_q + 16'd1;
        rd_addr_d = '0;
      end
      default: ;
    endcase
  end

  // TX write port and status outputs.
  always_comb begin
    bus.wr_ena  = 1'b0;
    bus.wr_addr = '0;
    wr_lane     = '0;
    unique case (state_q)
      ST_HDR: begin
        bus.wr_ena  = 1'b1;
        bus.wr_addr = cnt_q;
        wr_lane[0]  = hdr_word[31:24];
        wr_lane[1]  = hdr_word[23:16];
        wr_lane[2]  = hdr_word[15:8];
        wr_lane[3]  = hdr_word[7:0];
      end
      ST_PAYLOAD: begin
        bus.wr_ena  = 1'b1;
        bus.wr_addr = cnt_q;
        wr_lane[0]  = carry_q[7:0];
        wr_lane[1]  = carry_q[15:8];
        // Final word only holds the carried bytes.
        if (cnt_q != last_word) begin
          wr_lane[2] = bus.rd_data[7:0];
          wr_lane[3] = bus.rd_data[15:8];
        end
      end
      default: ;
    endcase
  end

  assign bus.wr_data   = {nibble_swap(wr_lane[3]), nibble_swap(wr_lane[2]),
                          nibble_swap(wr_lane[1]), nibble_swap(wr_lane[0])};
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.err       = err_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.last_addr = last_addr_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_eth_build.sv
// tb_eth_build: self-checking bench for eth_build with an expected-word
// scoreboard built from an independent byte-level frame model.
module tb_eth_build;
  import eth_pkg::*;

  localparam logic [47:0] T_SRC_MAC  = 48'h02_00_00_00_00_01;
  localparam logic [47:0] T_DST_MAC  = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [31:0] T_SRC_IP   = 32'hC0A8_0102;
  localparam logic [31:0] T_DST_IP   = 32'hC0A8_0101;
  localparam logic [15:0] T_SRC_PORT = 16'd4096;
  localparam logic [15:0] T_DST_PORT = 16'd4096;
  localparam logic [7:0]  T_TTL      = 8'd64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eth_build_if bus ();

  eth_build dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Payload RAM, one-cycle read latency.
  logic [31:0] pmem [0:511];
  always @(posedge clk) bus.rd_data <= pmem[bus.rd_addr];

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic [8:0]  exp_addr_q[$];
  logic [31:0] tx_mem [0:511];
  int          n_vec = 0;
  int          n_err = 0;
  int          done_cnt, err_cnt, wr_cnt;
  logic [8:0]  rd_max;
  logic        prev_wr = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] sw(input logic [7:0] b);
    return {b[3:0], b[7:4]};
  endfunction

  // Independent frame model: byte list -> nibble-swapped words on the queue.
  task automatic push_frame(input int len, input logic [15:0] id);
    logic [7:0]  fb[$];
    logic [15:0] hw[10];
    logic [31:0] sum;
    logic [15:0] ck, tl, ul;
    int          l;
    l  = len & 32'h7FC;
    tl = 16'(28 + l);
    ul = 16'(8 + l);
    hw = '{16'h4500, tl, id, 16'h4000, {T_TTL, 8'h11}, 16'h0000,
           T_SRC_IP[31:16], T_SRC_IP[15:0], T_DST_IP[31:16], T_DST_IP[15:0]};
    sum = 32'd0;
    foreach (hw[i]) sum += 32'(hw[i]);
    while (sum[31:16] != 16'd0) sum = 32'(sum[15:0]) + 32'(sum[31:16]);
    ck = ~sum[15:0];
    repeat (7) fb.push_back(8'h55);
    fb.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) fb.push_back(T_DST_MAC[8*i +: 8]);
    for (int i = 5; i >= 0; i--) fb.push_back(T_SRC_MAC[8*i +: 8]);
    fb.push_back(8'h08); fb.push_back(8'h00);
    fb.push_back(8'h45); fb.push_back(8'h00);
    fb.push_back(tl[15:8]); fb.push_back(tl[7:0]);
    fb.push_back(id[15:8]); fb.push_back(id[7:0]);
    fb.push_back(8'h40); fb.push_back(8'h00);
    fb.push_back(T_TTL); fb.push_back(8'h11);
    fb.push_back(ck[15:8]); fb.push_back(ck[7:0]);
    for (int i = 3; i >= 0; i--) fb.push_back(T_SRC_IP[8*i +: 8]);
    for (int i = 3; i >= 0; i--) fb.push_back(T_DST_IP[8*i +: 8]);
    fb.push_back(T_SRC_PORT[15:8]); fb.push_back(T_SRC_PORT[7:0]);
    fb.push_back(T_DST_PORT[15:8]); fb.push_back(T_DST_PORT[7:0]);
    fb.push_back(ul[15:8]); fb.push_back(ul[7:0]);
    fb.push_back(8'h00); fb.push_back(8'h00);
    for (int p = 0; p < l; p++) fb.push_back(pmem[p/4][8*(p%4) +: 8]);
    while (fb.size() % 4 != 0) fb.push_back(8'h00);
    for (int k = 0; k < fb.size() / 4; k++) begin
      exp_q.push_back({sw(fb[4*k+3]), sw(fb[4*k+2]), sw(fb[4*k+1]), sw(fb[4*k])});
      exp_addr_q.push_back(9'(k));
    end
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) done_cnt++;
      if (bus.err)  err_cnt++;
      if (bus.rd_addr > rd_max) rd_max = bus.rd_addr;
      if (bus.wr_ena) begin
        wr_cnt++;
        tx_mem[bus.wr_addr] = bus.wr_data;
        check_val("wr_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check_val("wr_addr", 32'(bus.wr_addr), 32'(exp_addr_q.pop_front()));
          check_val("wr_data", bus.wr_data, exp_q.pop_front());
        end
      end else if (prev_wr) begin
        check_val("wr_gap_remaining", 32'(exp_q.size()), 32'd0);
      end
      prev_wr = bus.wr_ena;
    end else begin
      prev_wr = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clr_counters();
    done_cnt = 0;
    err_cnt  = 0;
    wr_cnt   = 0;
    rd_max   = '0;
  endtask

  task automatic fill_pmem();
    for (int i = 0; i < 512; i++) pmem[i] = $urandom_range(32'hFFFF_FFFF, 0);
  endtask

  task automatic start_build(input logic [10:0] len);
    @(posedge clk); #1;
    bus.start       = 1'b1;
    bus.payload_len = len;
    @(posedge clk); #1;
    bus.start       = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    check_val(tag, 32'(i < budget), 32'd1);
  endtask

  task automatic settle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  function automatic logic [15:0] field16(input logic [31:0] w, input int lane);
    return {sw(w[8*lane +: 8]), sw(w[8*lane+8 +: 8])};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int i;
    bus.start       = 1'b0;
    bus.payload_len = '0;
    clr_counters();
    fill_pmem();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_wr_ena",    32'(bus.wr_ena), 32'd0);
    check_val("rst_done",      32'(bus.done), 32'd0);
    check_val("rst_err",       32'(bus.err), 32'd0);
    check_val("rst_busy",      32'(bus.busy), 32'd0);
    check_val("rst_rd_addr",   32'(bus.rd_addr), 32'd0);
    check_val("rst_wr_addr",   32'(bus.wr_addr), 32'd0);
    check_val("rst_wr_data",   bus.wr_data, 32'd0);
    check_val("rst_last_addr", 32'(bus.last_addr), 32'd0);
    check_val("rst_state",     32'(bus.state), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // L=16, ID 0: checksum against hand-computed reference
    clr_counters();
    push_frame(16, 16'd0);
    start_build(11'd16);
    wait_done("l16_id0_done", 200);
    settle(3);
    check_val("l16_id0_csum",  32'(field16(tx_mem[8], 0)), 32'h0000_B76D);
    check_val("l16_id0_wrcnt", 32'(wr_cnt), 32'd17);
    check_val("l16_id0_dones", 32'(done_cnt), 32'd1);

    // Second frame: ID 1, checksum one lower
    clr_counters();
    fill_pmem();
    push_frame(16, 16'd1);
    start_build(11'd16);
    wait_done("l16_id1_done", 200);
    settle(3);
    check_val("l16_id1_csum", 32'(field16(tx_mem[8], 0)), 32'h0000_B76C);
    check_val("l16_id1_id",   32'(field16(tx_mem[6], 2)), 32'd1);

    // L=4 with a known payload word
    clr_counters();
    pmem[0] = 32'h4433_2211;
    push_frame(4, 16'd2);
    start_build(11'd4);
    wait_done("l4_done", 200);
    check_val("l4_last_addr", 32'(bus.last_addr), 32'd13);
    settle(3);
    check_val("l4_word12", tx_mem[12], 32'h2211_0000);
    check_val("l4_word13", tx_mem[13], 32'h0000_4433);
    check_val("l4_wrcnt",  32'(wr_cnt), 32'd14);
    check_val("l4_dones",  32'(done_cnt), 32'd1);

    // Maximum payload
    clr_counters();
    fill_pmem();
    push_frame(1232, 16'd3);
    start_build(11'd1232);
    wait_done("l1232_done", 600);
    check_val("l1232_last_addr", 32'(bus.last_addr), 32'd320);
    settle(3);
    check_val("l1232_wrcnt",   32'(wr_cnt), 32'd321);
    check_val("l1232_ip_len",  32'(field16(tx_mem[6], 0)), 32'h0000_04EC);
    check_val("l1232_udp_len", 32'(field16(tx_mem[11], 2)), 32'h0000_04D8);
    check_val("l1232_rd_max",  32'(rd_max), 32'd307);

    // Rejected lengths: 0 and 1236
    clr_counters();
    start_build(11'd0);
    check_val("len0_err",      32'(bus.err), 32'd1);
    check_val("len0_busy",     32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check_val("len0_err_drop", 32'(bus.err), 32'd0);
    start_build(11'd1236);
    check_val("len1236_err",   32'(bus.err), 32'd1);
    settle(20);
    check_val("rej_err_cnt",   32'(err_cnt), 32'd2);
    check_val("rej_wr_cnt",    32'(wr_cnt), 32'd0);
    check_val("rej_state",     32'(bus.state), 32'(ST_IDLE));

    // payload_len=7 rounds down to 4
    clr_counters();
    fill_pmem();
    push_frame(7, 16'd4);
    start_build(11'd7);
    wait_done("len7_done", 200);
    check_val("len7_last_addr", 32'(bus.last_addr), 32'd13);
    settle(3);
    check_val("len7_wrcnt", 32'(wr_cnt), 32'd14);

    // start during PAYLOAD and DONE is ignored
    clr_counters();
    fill_pmem();
    push_frame(64, 16'd5);
    start_build(11'd64);
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.state == ST_PAYLOAD) break;
    end
    check_val("ign_reach_payload", 32'(i < 100), 32'd1);
    @(posedge clk); #1;
    bus.start       = 1'b1;
    bus.payload_len = 11'd8;
    @(posedge clk); #1;
    bus.start       = 1'b0;
    wait_done("ign_done", 200);
    bus.start       = 1'b1;
    bus.payload_len = 11'd16;
    @(posedge clk); #1;
    bus.start       = 1'b0;
    settle(20);
    check_val("ign_dones",     32'(done_cnt), 32'd1);
    check_val("ign_wrcnt",     32'(wr_cnt), 32'd29);
    check_val("ign_busy",      32'(bus.busy), 32'd0);
    check_val("ign_last_addr", 32'(bus.last_addr), 32'd28);
    check_val("ign_q_empty",   32'(exp_q.size()), 32'd0);

    // Reset in the middle of a frame
    clr_counters();
    fill_pmem();
    push_frame(400, 16'd6);
    start_build(11'd400);
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.wr_ena && bus.wr_addr == 9'd20) break;
    end
    check_val("mid_reach_w20", 32'(i < 200), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_wr_ena", 32'(bus.wr_ena), 32'd0);
    check_val("mid_rst_busy",   32'(bus.busy), 32'd0);
    exp_q.delete();
    exp_addr_q.delete();
    settle(2);
    rst_n = 1'b1;
    clr_counters();
    fill_pmem();
    push_frame(8, 16'd0);
    start_build(11'd8);
    wait_done("post_rst_done", 200);
    check_val("post_rst_last_addr", 32'(bus.last_addr), 32'd14);
    settle(3);
    check_val("post_rst_wrcnt", 32'(wr_cnt), 32'd15);
    check_val("post_rst_id",    32'(field16(tx_mem[6], 2)), 32'd0);
    check_val("final_q_empty",  32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
